accum_sched: RTL and testbench

Two-requester scheduler for a shared 4-sample accumulator. It arbitrates round-robin between two sources and grants one of them the accumulator for exactly four consecutive cycles. It then sums the four unsigned nibbles and presents the 6-bit result with a one-cycle valid strobe and the winning requester's ID. It sits between the sample producers and the downstream result consumer; the accumulator datapath is internal to this block.

---
 rtl/accum_sched_if.sv | 13 +
 rtl/accum_sched.sv | 53 +++++
 tb/tb_accum_sched.sv | 101 ++++++++++
 3 files changed

// File: rtl/accum_sched_if.sv
// accum_sched_if: request/sample/result bundle between producers, scheduler and consumer
interface accum_sched_if #(parameter int DATA_W = 4, parameter int SUM_W = 6);
    logic [1:0]        req;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [1:0]        gnt;
    logic              busy;
    logic [SUM_W-1:0]  sum;
    logic              sum_valid;
    logic              sum_id;
    modport master (output req, data0, data1, input gnt, busy, sum, sum_valid, sum_id);
    modport slave (input req, data0, data1, output gnt, busy, sum, sum_valid, sum_id);
endinterface

// File: rtl/accum_sched.sv
// accum_sched: round-robin two-requester scheduler feeding a 4-sample accumulator
module accum_sched (
    input logic clk,
    input logic reset,
    accum_sched_if.slave bus
);
    localparam int SUM_W = $bits(bus.sum);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state;
    logic [1:0] cnt;
    logic last;
    logic win;
    logic [SUM_W-1:0] word;
    // on contention the requester not granted last time wins
    assign win = &bus.req ? ~last : bus.req[1];
    assign word = SUM_W'(bus.gnt[1] ? bus.data1 : bus.data0);
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 2'd0;
            last <= 1'b1;
            bus.gnt <= 2'b00;
            bus.sum <= '0;
            bus.sum_valid <= 1'b0;
            bus.sum_id <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req) begin
                    bus.gnt <= 2'b01 << win;
                    bus.sum_id <= win;
                    last <= win;
                    cnt <= 2'd0;
                    state <= ACC;
                end
                ACC: begin
                    bus.sum <= (cnt == 2'd0) ? word : bus.sum + word;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        bus.gnt <= 2'b00;
                        bus.sum_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.sum_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: directed checks of grant order, sums, strobe timing and reset
module tb_accum_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errs = 0;
    int checks = 0;
    accum_sched_if bus ();
    accum_sched dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // one full operation: E0 grant, four words, strobe at E4, idle after E5
    task automatic do_op(input logic [1:0] r, input logic [1:0] eg, input logic [3:0] w0, w1, w2, w3,
                         input int es, input int ei, input bit keep_req);
        logic [3:0] w [4];
        w = '{w0, w1, w2, w3};
        bus.req = r;
        tick();
        check("grant", bus.gnt, eg);
        check("sum_id_e0", bus.sum_id, ei);
        check("busy_e0", bus.busy, 1);
        if (!keep_req) bus.req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            bus.data0 = eg[0] ? w[i] : 4'($urandom_range(0, 15));
            bus.data1 = eg[1] ? w[i] : 4'($urandom_range(0, 15));
            tick();
            if (i < 3) begin
                check("gnt_held", bus.gnt, eg);
                check("no_early_valid", bus.sum_valid, 0);
            end
        end
        check("gnt_drop", bus.gnt, 0);
        check("sum", bus.sum, es);
        check("sum_valid", bus.sum_valid, 1);
        check("sum_id", bus.sum_id, ei);
        tick();
        check("valid_clear", bus.sum_valid, 0);
        check("busy_e5", bus.busy, 0);
        check("sum_kept", bus.sum, es);
    endtask
    initial begin
        bus.req = 2'b00;
        bus.data0 = 4'd0;
        bus.data1 = 4'd0;
        tick();
        tick();
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_valid", bus.sum_valid, 0);
        check("rst_id", bus.sum_id, 0);
        reset = 1'b0;
        // single request, req dropped after grant, data1 random
        do_op(2'b01, 2'b01, 4'd3, 4'd5, 4'd7, 4'd9, 24, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_sum", bus.sum, 24);
            check("hold_valid", bus.sum_valid, 0);
            check("hold_gnt", bus.gnt, 0);
        end
        do_op(2'b10, 2'b10, 4'd15, 4'd15, 4'd15, 4'd15, 60, 1, 1'b0);
        // back-to-back contention starting after requester 1 was last
        do_op(2'b11, 2'b01, 4'd1, 4'd1, 4'd1, 4'd1, 4, 0, 1'b1);
        do_op(2'b11, 2'b10, 4'd2, 4'd2, 4'd2, 4'd2, 8, 1, 1'b1);
        do_op(2'b11, 2'b01, 4'd1, 4'd1, 4'd1, 4'd1, 4, 0, 1'b1);
        do_op(2'b11, 2'b10, 4'd2, 4'd2, 4'd2, 4'd2, 8, 1, 1'b0);
        // reset on the second ACC edge after granting requester 0
        bus.req = 2'b01;
        tick();
        check("mid_grant", bus.gnt, 1);
        bus.req = 2'b00;
        bus.data0 = 4'd5;
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_gnt", bus.gnt, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sum", bus.sum, 0);
        check("mid_rst_valid", bus.sum_valid, 0);
        check("mid_rst_id", bus.sum_id, 0);
        bus.req = 2'b11;
        tick();
        check("rst_req_gnt", bus.gnt, 0);
        check("rst_req_busy", bus.busy, 0);
        tick();
        check("no_late_valid", bus.sum_valid, 0);
        reset = 1'b0;
        do_op(2'b11, 2'b01, 4'd4, 4'd0, 4'd8, 4'd1, 13, 0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
